// File: rtl/fp_unpack_stage_if.sv
// Handshaked bundle between the operand source and the dot-product unpack stage.
// The master side issues input beats and accepts unpacked results; the slave side
// is the unpack stage itself.
interface fp_unpack_stage_if #(
    parameter int LANES = 4
);
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*32-1:0] data_a;
    logic [LANES*32-1:0] data_b;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_fmt;
    logic [LANES-1:0]    sign_a;
    logic [LANES-1:0]    sign_b;
    logic [LANES*8-1:0]  exp_a;
    logic [LANES*8-1:0]  exp_b;
    logic [LANES*12-1:0] sigl_a;
    logic [LANES*12-1:0] sigl_b;
    logic [LANES*13-1:0] sigr_a;
    logic [LANES*13-1:0] sigr_b;
    logic [LANES*2-1:0]  cls_a;
    logic [LANES*2-1:0]  cls_b;

    modport master (
        output mode, in_valid, data_a, data_b, out_ready,
        input  in_ready, out_valid, out_fmt, sign_a, sign_b, exp_a, exp_b,
               sigl_a, sigl_b, sigr_a, sigr_b, cls_a, cls_b
    );

    modport slave (
        input  mode, in_valid, data_a, data_b, out_ready,
        output in_ready, out_valid, out_fmt, sign_a, sign_b, exp_a, exp_b,
               sigl_a, sigl_b, sigr_a, sigr_b, cls_a, cls_b
    );
endinterface

// File: rtl/fp_unpack_stage.sv
// Front-end of the multi-precision dot-product unit. Each beat carries LANES operand
// pairs in FP32, FP16 or BF16 (chosen per beat, or auto-detected). Every operand is
// split into sign, effective exponent, Q2.10 left significand, 13-bit right
// significand and a class code. Results sit in a two-entry skid buffer (main + skid)
// so that in_ready is a plain register and never follows out_ready combinationally.
module fp_unpack_stage #(
    parameter int LANES     = 4,
    parameter int AUTO_LANE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_unpack_stage_if.slave bus
);
    // A single-lane build has only lane 0 to look at for auto-detect.
    localparam int AL = (LANES == 1) ? 0 : AUTO_LANE;

    localparam logic [1:0] FMT_FP16 = 2'b00;
    localparam logic [1:0] FMT_FP32 = 2'b01;
    localparam logic [1:0] FMT_BF16 = 2'b10;

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [11:0] sigl;
        logic [12:0] sigr;
        logic [1:0]  cls;
    } op_t;

    // Class code from the raw exponent/mantissa shape. Subnormals count as normal.
    function automatic logic [1:0] classify(input logic e_zero, input logic e_ones,
                                            input logic m_zero);
        logic [1:0] c;
        if (e_zero) begin
            c = m_zero ? CLS_ZERO : CLS_NORM;
        end else if (e_ones) begin
            c = m_zero ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    // Split one 32-bit lane word. The mantissa is left-aligned into 23 bits for all
    // formats, so the top 10 bits always feed sigl and the low 13 bits feed sigr
    // (which are zero by construction for the 16-bit formats).
    function automatic op_t unpack_op(input logic [31:0] x, input logic [1:0] fmt);
        op_t         r;
        logic        sgn;
        logic [7:0]  e_raw;
        logic        e_ones;
        logic [22:0] m;
        logic        e_zero;
        logic        m_zero;
        case (fmt)
            FMT_FP32: begin
                sgn    = x[31];
                e_raw  = x[30:23];
                e_ones = &x[30:23];
                m      = x[22:0];
            end
            FMT_BF16: begin
                sgn    = x[15];
                e_raw  = x[14:7];
                e_ones = &x[14:7];
                m      = {x[6:0], 16'h0000};
            end
            default: begin
                sgn    = x[15];
                e_raw  = {3'b000, x[14:10]};
                e_ones = &x[14:10];
                m      = {x[9:0], 13'h0000};
            end
        endcase
        e_zero = (e_raw == 8'd0);
        m_zero = (m == 23'd0);
        r.sgn  = sgn;
        // Subnormals use an effective exponent of 1 with a zero hidden bit.
        r.exp  = (e_zero && !m_zero) ? 8'd1 : e_raw;
        r.sigl = {1'b0, !e_zero, m[22:13]};
        r.sigr = m[12:0];
        r.cls  = classify(e_zero, e_ones, m_zero);
        return r;
    endfunction

    // Incoming beat, unpacked
    logic [1:0]            in_fmt_s;
    op_t [LANES-1:0]       in_a_s;
    op_t [LANES-1:0]       in_b_s;

    // Skid buffer state
    logic                  m_full_r;
    logic                  s_full_r;
    logic                  in_ready_r;
    logic [1:0]            m_fmt_r;
    op_t [LANES-1:0]       m_a_r;
    op_t [LANES-1:0]       m_b_r;
    logic [1:0]            s_fmt_r;
    op_t [LANES-1:0]       s_a_r;
    op_t [LANES-1:0]       s_b_r;

    // Control next-state
    logic                  accept_s;
    logic                  drain_s;
    logic                  m_full_n_s;
    logic                  s_full_n_s;
    logic                  load_m_in_s;
    logic                  load_m_skid_s;
    logic                  load_s_s;

    // Resolve the beat format; auto mode looks at the a-exponent of the chosen lane.
    always_comb begin
        in_fmt_s = FMT_FP16;
        case (bus.mode)
            2'b00:   in_fmt_s = FMT_FP16;
            2'b01:   in_fmt_s = FMT_FP32;
            2'b10:   in_fmt_s = FMT_BF16;
            default: in_fmt_s = (|bus.data_a[AL*32+23 +: 8]) ? FMT_FP32 : FMT_FP16;
        endcase
    end

    // Unpack every operand of the incoming beat under its resolved format.
    always_comb begin
        in_a_s = '0;
        in_b_s = '0;
        for (int i = 0; i < LANES; i++) begin
            in_a_s[i] = unpack_op(bus.data_a[32*i +: 32], in_fmt_s);
            in_b_s[i] = unpack_op(bus.data_b[32*i +: 32], in_fmt_s);
        end
    end

    // Decide where an accepted beat goes and how the two entries move this cycle.
    always_comb begin
        accept_s      = bus.in_valid & in_ready_r;
        drain_s       = m_full_r & bus.out_ready;
        m_full_n_s    = m_full_r;
        s_full_n_s    = s_full_r;
        load_m_in_s   = 1'b0;
        load_m_skid_s = 1'b0;
        load_s_s      = 1'b0;
        if (drain_s && s_full_r) begin
            // in_ready is low while S is full, so no accept can coincide here.
            load_m_skid_s = 1'b1;
            m_full_n_s    = 1'b1;
            s_full_n_s    = 1'b0;
        end else if (accept_s && (!m_full_r || drain_s)) begin
            load_m_in_s = 1'b1;
            m_full_n_s  = 1'b1;
        end else if (accept_s) begin
            load_s_s   = 1'b1;
            s_full_n_s = 1'b1;
        end else if (drain_s) begin
            m_full_n_s = 1'b0;
        end else begin
            m_full_n_s = m_full_r;
        end
    end

    // Occupancy flags and the registered ready, which tracks the next skid state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full_r   <= 1'b0;
            s_full_r   <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            m_full_r   <= m_full_n_s;
            s_full_r   <= s_full_n_s;
            in_ready_r <= !s_full_n_s;
        end
    end

    // Payload storage for the main and skid entries; M holds its value while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fmt_r <= FMT_FP16;
            m_a_r   <= '0;
            m_b_r   <= '0;
            s_fmt_r <= FMT_FP16;
            s_a_r   <= '0;
            s_b_r   <= '0;
        end else begin
            if (load_m_skid_s) begin
                m_fmt_r <= s_fmt_r;
                m_a_r   <= s_a_r;
                m_b_r   <= s_b_r;
            end else if (load_m_in_s) begin
                m_fmt_r <= in_fmt_s;
                m_a_r   <= in_a_s;
                m_b_r   <= in_b_s;
            end
            if (load_s_s) begin
                s_fmt_r <= in_fmt_s;
                s_a_r   <= in_a_s;
                s_b_r   <= in_b_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = m_full_r;
    assign bus.out_fmt   = m_fmt_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign bus.sign_a[g]          = m_a_r[g].sgn;
        assign bus.sign_b[g]          = m_b_r[g].sgn;
        assign bus.exp_a[8*g +: 8]    = m_a_r[g].exp;
        assign bus.exp_b[8*g +: 8]    = m_b_r[g].exp;
        assign bus.sigl_a[12*g +: 12] = m_a_r[g].sigl;
        assign bus.sigl_b[12*g +: 12] = m_b_r[g].sigl;
        assign bus.sigr_a[13*g +: 13] = m_a_r[g].sigr;
        assign bus.sigr_b[13*g +: 13] = m_b_r[g].sigr;
        assign bus.cls_a[2*g +: 2]    = m_a_r[g].cls;
        assign bus.cls_b[2*g +: 2]    = m_b_r[g].cls;
    end
endmodule

// File: tb/tb_fp_unpack_stage.sv
// Bench for fp_unpack_stage: directed vectors with hand-computed expected fields,
// a scoreboard queue filled at acceptance and a monitor that pops on every output
// transfer and checks hold-stability while stalled.
module tb_fp_unpack_stage;
    localparam int NV = 14;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [11:0] sigl;
        logic [12:0] sigr;
        logic [1:0]  cls;
    } op_t;

    typedef struct packed {
        logic [1:0] fmt;
        op_t [3:0]  a;
        op_t [3:0]  b;
    } beat_t;

    logic clk;
    logic rst_n;

    fp_unpack_stage_if #(.LANES(4)) bus ();

    fp_unpack_stage #(.LANES(4), .AUTO_LANE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int    checks = 0;
    int    errors = 0;
    int    beat_no = 0;
    beat_t q[$];

    logic       rdy_rand = 1'b0;
    logic       rdy_val  = 1'b1;

    logic [1:0]  v_mode [NV];
    logic [31:0] v_a0 [NV];
    logic [31:0] v_a1 [NV];
    logic [31:0] v_b0 [NV];
    logic [1:0]  v_fmt [NV];
    op_t         v_ea0 [NV];
    op_t         v_ea1 [NV];
    op_t         v_eb0 [NV];
    op_t         zop;

    logic [290:0] out_bus;
    assign out_bus = {bus.out_valid, bus.out_fmt, bus.sign_a, bus.sign_b, bus.exp_a, bus.exp_b,
                      bus.sigl_a, bus.sigl_b, bus.sigr_a, bus.sigr_b, bus.cls_a, bus.cls_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic op_t mk(input logic s, input logic [7:0] e, input logic [11:0] sl,
                               input logic [12:0] sr, input logic [1:0] c);
        op_t r;
        r.sgn = s; r.exp = e; r.sigl = sl; r.sigr = sr; r.cls = c;
        return r;
    endfunction

    task automatic set_vec(input int i, input logic [1:0] md, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] b0, input logic [1:0] f,
                           input op_t ea0, input op_t ea1, input op_t eb0);
        v_mode[i] = md; v_a0[i] = a0; v_a1[i] = a1; v_b0[i] = b0; v_fmt[i] = f;
        v_ea0[i] = ea0; v_ea1[i] = ea1; v_eb0[i] = eb0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Drive one vector; push its expectation once in_ready shows it will be taken.
    task automatic send(input int idx, output int waited);
        beat_t e;
        bit    done;
        waited = 0;
        done   = 1'b0;
        bus.mode     = v_mode[idx];
        bus.data_a   = {64'h0, v_a1[idx], v_a0[idx]};
        bus.data_b   = {96'h0, v_b0[idx]};
        bus.in_valid = 1'b1;
        e.fmt = v_fmt[idx];
        e.a   = {zop, zop, v_ea1[idx], v_ea0[idx]};
        e.b   = {zop, zop, zop, v_eb0[idx]};
        while (!done && waited < 100) begin
            if (bus.in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout vec%0d: in_ready low for %0d cycles, required 1", idx, waited);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.data_a   = '0;
        bus.data_b   = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    // out_ready driver: a fixed level or a random coin per cycle
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: pop and compare on each transfer; check hold stability while stalled
    initial begin
        logic         held;
        logic [290:0] snap;
        beat_t        e;
        op_t          act;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (out_bus !== snap) begin
                        errors++;
                        $display("FAIL stall_hold: outputs changed while stalled, got %h required %h",
                                 out_bus, snap);
                    end
                    held = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got out_valid=1 with fmt %b, required no beat", bus.out_fmt);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("beat%0d fmt", beat_no), 32'(bus.out_fmt), 32'(e.fmt));
                        for (int i = 0; i < 4; i++) begin
                            act = mk(bus.sign_a[i], bus.exp_a[8*i +: 8], bus.sigl_a[12*i +: 12],
                                     bus.sigr_a[13*i +: 13], bus.cls_a[2*i +: 2]);
                            chk($sformatf("beat%0d a%0d {s,e,sigl,sigr,cls}", beat_no, i), 32'(act), 32'(e.a[i]));
                            act = mk(bus.sign_b[i], bus.exp_b[8*i +: 8], bus.sigl_b[12*i +: 12],
                                     bus.sigr_b[13*i +: 13], bus.cls_b[2*i +: 2]);
                            chk($sformatf("beat%0d b%0d {s,e,sigl,sigr,cls}", beat_no, i), 32'(act), 32'(e.b[i]));
                        end
                        beat_no++;
                    end
                end else if (bus.out_valid) begin
                    held = 1'b1;
                    snap = out_bus;
                end
            end
        end
    end

    // Main sequence
    initial begin
        int w;
        int stalls;
        zop = mk(1'b0, 8'h00, 12'h000, 13'h0000, 2'b01);
        set_vec(0,  2'b01, 32'h3FC00000, 32'h0, 32'h0, 2'b01,
                mk(1'b0, 8'h7F, 12'h600, 13'h0000, 2'b00), zop, zop);
        set_vec(1,  2'b11, 32'h00003C00, 32'h00003C00, 32'h0, 2'b00,
                mk(1'b0, 8'h0F, 12'h400, 13'h0000, 2'b00), mk(1'b0, 8'h0F, 12'h400, 13'h0000, 2'b00), zop);
        set_vec(2,  2'b11, 32'h0, 32'h3F800000, 32'h0, 2'b01,
                zop, mk(1'b0, 8'h7F, 12'h400, 13'h0000, 2'b00), zop);
        set_vec(3,  2'b10, 32'h00003FC0, 32'h0, 32'h0, 2'b10,
                mk(1'b0, 8'h7F, 12'h600, 13'h0000, 2'b00), zop, zop);
        set_vec(4,  2'b00, 32'h00000001, 32'h0, 32'h0, 2'b00,
                mk(1'b0, 8'h01, 12'h001, 13'h0000, 2'b00), zop, zop);
        set_vec(5,  2'b00, 32'h00007C00, 32'h0, 32'h00007E00, 2'b00,
                mk(1'b0, 8'h1F, 12'h400, 13'h0000, 2'b10), zop, mk(1'b0, 8'h1F, 12'h600, 13'h0000, 2'b11));
        set_vec(6,  2'b00, 32'h00008000, 32'h0, 32'h0, 2'b00,
                mk(1'b1, 8'h00, 12'h000, 13'h0000, 2'b01), zop, zop);
        set_vec(7,  2'b01, 32'hBF800001, 32'h0, 32'h7F800000, 2'b01,
                mk(1'b1, 8'h7F, 12'h400, 13'h0001, 2'b00), zop, mk(1'b0, 8'hFF, 12'h400, 13'h0000, 2'b10));
        set_vec(8,  2'b01, 32'h00400000, 32'h0, 32'h7FC00001, 2'b01,
                mk(1'b0, 8'h01, 12'h200, 13'h0000, 2'b00), zop, mk(1'b0, 8'hFF, 12'h600, 13'h0001, 2'b11));
        set_vec(9,  2'b00, 32'hABCD3C00, 32'h7F800000, 32'h000083FF, 2'b00,
                mk(1'b0, 8'h0F, 12'h400, 13'h0000, 2'b00), zop, mk(1'b1, 8'h01, 12'h3FF, 13'h0000, 2'b00));
        set_vec(10, 2'b10, 32'h0000FF80, 32'h00000041, 32'h00007F81, 2'b10,
                mk(1'b1, 8'hFF, 12'h400, 13'h0000, 2'b10), mk(1'b0, 8'h01, 12'h208, 13'h0000, 2'b00),
                mk(1'b0, 8'hFF, 12'h408, 13'h0000, 2'b11));
        set_vec(11, 2'b11, 32'h3F800000, 32'h0, 32'h0, 2'b00, zop, zop, zop);
        set_vec(12, 2'b11, 32'h00000001, 32'h80000000, 32'h0, 2'b00,
                mk(1'b0, 8'h01, 12'h001, 13'h0000, 2'b00), zop, zop);
        set_vec(13, 2'b01, 32'h80000000, 32'h7F7FFFFF, 32'h0, 2'b01,
                mk(1'b1, 8'h00, 12'h000, 13'h0000, 2'b01), mk(1'b0, 8'hFE, 12'h7FF, 13'h1FFF, 2'b00), zop);

        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_fmt", 32'(bus.out_fmt), 32'd0);
        chk("reset data_zero", 32'(|out_bus[287:0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle out_valid", 32'(bus.out_valid), 32'd0);

        // Directed vectors back-to-back at full throughput
        stalls = 0;
        for (int i = 0; i < NV; i++) begin
            send(i, w);
            stalls += w;
        end
        idle();
        chk("full_rate stalls", 32'(stalls), 32'd0);
        wait_drain("drain_directed queue_left");

        // Stall: fill M and S, hold out_ready low, then release
        rdy_val = 1'b0;
        @(posedge clk); #1;
        send(0, w);
        send(3, w);
        idle();
        chk("stall in_ready_low", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall still_full out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall still_full in_ready", 32'(bus.in_ready), 32'd0);
        rdy_val = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid_stays", 32'(bus.out_valid), 32'd1);
        chk("release in_ready_back", 32'(bus.in_ready), 32'd1);
        send(5, w);
        send(10, w);
        idle();
        wait_drain("drain_stall queue_left");

        // Reset with both entries occupied
        rdy_val = 1'b0;
        @(posedge clk); #1;
        send(7, w);
        send(8, w);
        idle();
        chk("prereset in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_reset data_zero", 32'(|out_bus[287:0]), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_val = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_reset out_valid", 32'(bus.out_valid), 32'd0);
            chk("post_reset in_ready", 32'(bus.in_ready), 32'd1);
        end
        send(2, w);
        idle();
        wait_drain("drain_after_reset queue_left");

        // Random valid/ready over the directed vector pool
        rdy_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send(k % NV, w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        wait_drain("drain_random queue_left");
        repeat (3) @(posedge clk);
        #1;
        chk("final out_valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
